// File: rtl/dmem_arbiter.sv
// Per-cycle arbiter sharing one single-port data memory between the CPU and a DMA/debug port.
// Optional build macro DMARB_STATS_EN adds saturating per-side stall counters.
module dmem_arbiter #(
   parameter int AW        = 9,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
`ifdef DMARB_STATS_EN
   output logic [15:0]   cpu_stall_cnt,
   output logic [15:0]   dma_stall_cnt,
`endif
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

   owner_t     owner_r, owner_nxt;
   logic [3:0] cnt_r, cnt_nxt;
   logic       cpu_gnt_s, dma_gnt_s;
   logic       cpu_rvalid_r, dma_rvalid_r;

   // Grant decision: uncontended requests win at once, contention follows the burst limit.
   always_comb begin
      cpu_gnt_s = 1'b0;
      dma_gnt_s = 1'b0;
      if (rst) begin
         cpu_gnt_s = 1'b0;
      end else if (cpu_req && !dma_req) begin
         cpu_gnt_s = 1'b1;
      end else if (dma_req && !cpu_req) begin
         dma_gnt_s = 1'b1;
      end else if (cpu_req && dma_req) begin
         case (owner_r)
            OWN_CPU: begin
               if (cnt_r < MAX_CNT) cpu_gnt_s = 1'b1;
               else                 dma_gnt_s = 1'b1;
            end
            OWN_DMA: begin
               if (cnt_r < MAX_CNT) dma_gnt_s = 1'b1;
               else                 cpu_gnt_s = 1'b1;
            end
            default: cpu_gnt_s = 1'b1;
         endcase
      end else begin
         cpu_gnt_s = 1'b0;
      end
   end

   always_comb begin
      owner_nxt = owner_r;
      cnt_nxt   = cnt_r;
      if (cpu_gnt_s) begin
         if (owner_r == OWN_CPU) begin
            if (cnt_r >= MAX_CNT) cnt_nxt = MAX_CNT;
            else                  cnt_nxt = cnt_r + 4'd1;
         end else begin
            owner_nxt = OWN_CPU;
            cnt_nxt   = 4'd1;
         end
      end else if (dma_gnt_s) begin
         if (owner_r == OWN_DMA) begin
            if (cnt_r >= MAX_CNT) cnt_nxt = MAX_CNT;
            else                  cnt_nxt = cnt_r + 4'd1;
         end else begin
            owner_nxt = OWN_DMA;
            cnt_nxt   = 4'd1;
         end
      end else begin
         owner_nxt = OWN_NONE;
         cnt_nxt   = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_r <= OWN_NONE;
         cnt_r   <= 4'd0;
      end else begin
         owner_r <= owner_nxt;
         cnt_r   <= cnt_nxt;
      end
   end

   always_comb begin
      mem_wen  = 1'b0;
      mem_addr = {AW{1'b0}};
      mem_din  = {DW{1'b0}};
      if (cpu_gnt_s) begin
         mem_wen  = cpu_we;
         mem_addr = cpu_addr;
         mem_din  = cpu_wdata;
      end else if (dma_gnt_s) begin
         mem_wen  = dma_we;
         mem_addr = dma_addr;
         mem_din  = dma_wdata;
      end else begin
         mem_wen  = 1'b0;
      end
   end

   // Read return: rdata only moves on a granted read by the same side.
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rvalid_r <= 1'b0;
         dma_rvalid_r <= 1'b0;
         cpu_rdata    <= {DW{1'b0}};
         dma_rdata    <= {DW{1'b0}};
      end else begin
         cpu_rvalid_r <= cpu_gnt_s & ~cpu_we;
         dma_rvalid_r <= dma_gnt_s & ~dma_we;
         if (cpu_gnt_s && !cpu_we) cpu_rdata <= mem_dout;
         if (dma_gnt_s && !dma_we) dma_rdata <= mem_dout;
      end
   end

   // A reset arriving while a read return is pending hides that strobe immediately.
   assign cpu_rvalid = cpu_rvalid_r & ~rst;
   assign dma_rvalid = dma_rvalid_r & ~rst;
   assign cpu_gnt    = cpu_gnt_s;
   assign dma_gnt    = dma_gnt_s;

`ifdef DMARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_stall_cnt <= 16'd0;
         dma_stall_cnt <= 16'd0;
      end else begin
         if (cpu_req && !cpu_gnt_s && (cpu_stall_cnt != 16'hFFFF)) cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
         if (dma_req && !dma_gnt_s && (dma_stall_cnt != 16'hFFFF)) dma_stall_cnt <= dma_stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a run-length arbitration model.
module tb_dmem_arbiter;
   localparam int AW = 9;
   localparam int DW = 32;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          dma_req = 1'b0, dma_we = 1'b0;
   logic [AW-1:0] dma_addr = '0;
   logic [DW-1:0] dma_wdata = '0;
   logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_wen;
   logic [DW-1:0] cpu_rdata, dma_rdata, mem_din, mem_dout;
   logic [AW-1:0] mem_addr;
`ifdef DMARB_STATS_EN
   logic [15:0]   cpu_stall_cnt, dma_stall_cnt;
`endif

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
`ifdef DMARB_STATS_EN
      .cpu_stall_cnt(cpu_stall_cnt), .dma_stall_cnt(dma_stall_cnt),
`endif
      .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // DATAMEM stand-in: synchronous write, combinational read
   logic [DW-1:0] mem [0:(1<<AW)-1];
   assign mem_dout = mem[mem_addr];
   always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_din;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: last granted side, length of its current run, shadow memory
   int            last_side = 0;   // 0 none, 1 cpu, 2 dma
   int            streak    = 0;
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic          exp_cpu_rv = 1'b0, exp_dma_rv = 1'b0;
   logic [DW-1:0] exp_cpu_rd = '0, exp_dma_rd = '0;
   int            cpu_stalls = 0, dma_stalls = 0;
   int            last_grant = 0;

   task automatic step(input logic r, input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd);
      int g;
      @(negedge clk);
      rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
      #1;
      if (r)                 g = 0;
      else if (cr && !dr)    g = 1;
      else if (dr && !cr)    g = 2;
      else if (cr && dr) begin
         if (last_side == 0)   g = 1;
         else if (streak < MB) g = last_side;
         else                  g = 3 - last_side;
      end else g = 0;
      last_grant = g;

      check_eq("cpu_gnt", 64'(cpu_gnt), 64'(g == 1));
      check_eq("dma_gnt", 64'(dma_gnt), 64'(g == 2));
      check_eq("gnt_excl", 64'(cpu_gnt & dma_gnt), 64'd0);
      check_eq("mem_wen", 64'(mem_wen), 64'((g == 1 && cw) || (g == 2 && dw)));
      check_eq("mem_addr", 64'(mem_addr), (g == 1) ? 64'(ca) : (g == 2) ? 64'(da) : 64'd0);
      check_eq("mem_din", 64'(mem_din), (g == 1) ? 64'(cd) : (g == 2) ? 64'(dd) : 64'd0);
      check_eq("cpu_rvalid", 64'(cpu_rvalid), 64'(exp_cpu_rv & ~r));
      check_eq("dma_rvalid", 64'(dma_rvalid), 64'(exp_dma_rv & ~r));
      check_eq("cpu_rdata", 64'(cpu_rdata), 64'(exp_cpu_rd));
      check_eq("dma_rdata", 64'(dma_rdata), 64'(exp_dma_rd));
`ifdef DMARB_STATS_EN
      check_eq("cpu_stall_cnt", 64'(cpu_stall_cnt), 64'(cpu_stalls));
      check_eq("dma_stall_cnt", 64'(dma_stall_cnt), 64'(dma_stalls));
`endif

      if (r) begin
         last_side = 0; streak = 0;
         exp_cpu_rv = 1'b0; exp_dma_rv = 1'b0;
         exp_cpu_rd = '0;   exp_dma_rd = '0;
         cpu_stalls = 0;    dma_stalls = 0;
      end else begin
         exp_cpu_rv = (g == 1) && !cw;
         exp_dma_rv = (g == 2) && !dw;
         if (g == 1 && !cw) exp_cpu_rd = ref_mem[ca];
         if (g == 2 && !dw) exp_dma_rd = ref_mem[da];
         if (g == 1 && cw)  ref_mem[ca] = cd;
         if (g == 2 && dw)  ref_mem[da] = dd;
         if (g == 0)              begin last_side = 0; streak = 0; end
         else if (g == last_side) streak = streak + 1;
         else                     begin last_side = g; streak = 1; end
         if (cr && g != 1 && cpu_stalls < 65535) cpu_stalls++;
         if (dr && g != 2 && dma_stalls < 65535) dma_stalls++;
      end
   endtask

   string pattern;

   initial begin
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
      repeat (3) @(posedge clk);
      step(1'b1, 1'b1, 1'b0, 9'h000, 32'h0, 1'b1, 1'b0, 9'h000, 32'h0);
      step(1'b1, 1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0);

      // Clear the low address window through the DMA port so shadow and memory agree
      for (int i = 0; i < 32; i++)
         step(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b1, 1'b1, 9'(i), 32'h0);
      step(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b1, 1'b1, 9'h010, 32'hDEADBEEF);

      // Uncontended CPU read, data one cycle later
      step(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0);
      step(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0);
      check_eq("cpu_read_deadbeef", 64'(cpu_rdata), 64'h00000000DEADBEEF);

      // Continuous contention from an idle owner
      pattern = "";
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b1, 1'b0, 9'(i), 32'h0, 1'b1, 1'b0, 9'(i + 1), 32'h0);
         pattern = {pattern, (cpu_gnt ? "C" : dma_gnt ? "D" : "-")};
      end
      check_eq("burst_pattern", 64'(pattern == "CCCCDDDDCCCC"), 64'd1);

      // CPU write then DMA read of the same word
      step(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0);
      step(1'b0, 1'b1, 1'b1, 9'h020, 32'h12345678, 1'b0, 1'b0, 9'h000, 32'h0);
      step(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b1, 1'b0, 9'h020, 32'h0);
      step(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0);
      check_eq("dma_read_after_cpu_write", 64'(dma_rdata), 64'h0000000012345678);

      // DMA alone, one idle cycle, then contention: owner forgotten, CPU first
      step(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b1, 1'b0, 9'h001, 32'h0);
      step(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0);
      step(1'b0, 1'b1, 1'b0, 9'h002, 32'h0, 1'b1, 1'b0, 9'h003, 32'h0);
      check_eq("idle_resets_owner", 64'(last_grant), 64'd1);

      // Reset right after a granted read hides the strobe; CPU wins afterwards
      step(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0);
      step(1'b1, 1'b1, 1'b0, 9'h010, 32'h0, 1'b1, 1'b0, 9'h011, 32'h0);
      step(1'b0, 1'b1, 1'b0, 9'h010, 32'h0, 1'b1, 1'b0, 9'h011, 32'h0);
      check_eq("post_reset_cpu_first", 64'(last_grant), 64'd1);

`ifdef DMARB_STATS_EN
      // DMA blocked for the four cycles of a CPU burst
      step(1'b1, 1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 1'b0, 9'h000, 32'h0);
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b1, 1'b0, 9'(i), 32'h0, 1'b1, 1'b0, 9'h000, 32'h0);
      check_eq("dma_stalls_4", 64'(dma_stall_cnt), 64'd4);
      check_eq("cpu_stalls_0", 64'(cpu_stall_cnt), 64'd0);
`endif

      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 63) == 0),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 31)), $urandom,
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 31)), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
